// File: rtl/key_matrix_scan_if.sv
// Keypad scanner interface: pin side (rows/columns) and debounced event side.
interface key_matrix_scan_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int NKEYS = ROWS * COLS;
  localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;

  logic [ROWS-1:0]  Key_Row;
  logic [COLS-1:0]  Key_Col;
  logic [NKEYS-1:0] Key_State;
  logic             Key_Flag;
  logic             Key_Press;
  logic [KW-1:0]    Key_Value;
  logic             Key_Multi;

  // Scanner side: samples rows, drives columns and publishes key events
  modport master (
    input  Key_Row,
    output Key_Col, Key_State, Key_Flag, Key_Press, Key_Value, Key_Multi
  );

  // Keypad/consumer side: drives rows, observes columns and events
  modport slave (
    output Key_Row,
    input  Key_Col, Key_State, Key_Flag, Key_Press, Key_Value, Key_Multi
  );
endinterface

// File: rtl/key_matrix_scan.sv
// ROWS x COLS matrix keypad scanner with whole-frame debouncing and
// per-key press/release event generation.
module key_matrix_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 5
) (
  input logic               Clk,
  input logic               Rst_n,
  key_matrix_scan_if.master kp
);

  localparam int NKEYS = ROWS * COLS;
  localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW    = $clog2(SCAN_DIV);
  localparam int DW    = $clog2(DEB_FRAMES);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_FRAMES - 1);
  localparam logic [KW-1:0] IDX_LAST  = KW'(NKEYS - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  row_sync;
  logic [SW-1:0]    slot_cnt;
  logic [CW-1:0]    col_idx;
  logic [CW-1:0]    col_next;
  logic [COLS-1:0]  key_col_q;
  logic [NKEYS-1:0] raw_q;
  logic [NKEYS-1:0] frame_next;
  logic [NKEYS-1:0] prev_frame_q;
  logic [DW-1:0]    stable_q;
  logic [DW-1:0]    stable_next;
  logic [NKEYS-1:0] key_state_q;
  logic [NKEYS-1:0] diff_q;
  logic             slot_end;
  logic             frame_end;
  logic             frame_same;
  logic             accept;
  state_t           state_q;
  state_t           state_d;
  logic [KW-1:0]    emit_idx;
  logic             emit_hit;
  logic             emit_press;
  logic             emit_last;
  logic             flag_q;
  logic             press_q;
  logic [KW-1:0]    value_q;
  logic             multi_q;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (col_idx == COL_LAST);
  assign col_next  = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;

  // Two-flop synchronizer for the asynchronous row lines; idle rows read high
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= kp.Key_Row;
      row_sync <= row_meta;
    end
  end

  // Current frame with the active column's row samples merged in (rows are active low)
  always_comb begin
    frame_next = raw_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (col_idx == CW'(c)) begin
          frame_next[r*COLS + c] = ~row_sync[r];
        end
      end
    end
  end

  // Column slot timer: sample at the end of each slot, then move the low column on
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      slot_cnt  <= '0;
      col_idx   <= '0;
      key_col_q <= ~(COLS'(1));
      raw_q     <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      col_idx   <= col_next;
      key_col_q <= ~(COLS'(1) << col_next);
      raw_q     <= frame_next;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  assign frame_same  = (frame_next == prev_frame_q);
  assign stable_next = !frame_same ? '0 :
                       (stable_q == DEB_LAST) ? stable_q : stable_q + 1'b1;
  assign accept      = frame_end && (stable_next == DEB_LAST) &&
                       (frame_next != key_state_q);

  // Frame debouncer: a bitmap is accepted after DEB_FRAMES identical frames in a row
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev_frame_q <= '0;
      stable_q     <= '0;
      key_state_q  <= '0;
      diff_q       <= '0;
    end else if (frame_end) begin
      prev_frame_q <= frame_next;
      stable_q     <= stable_next;
      if (accept) begin
        diff_q      <= frame_next ^ key_state_q;
        key_state_q <= frame_next;
      end
    end
  end

  // Event FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Event FSM next state: a new bitmap starts a full walk over every key index
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = EMIT;
      EMIT:    if (emit_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Event FSM outputs: whether the key under the walk pointer changed, and its new level
  always_comb begin
    emit_hit   = 1'b0;
    emit_press = 1'b0;
    emit_last  = 1'b0;
    if (state_q == EMIT) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (emit_idx == KW'(i)) begin
          emit_hit   = diff_q[i];
          emit_press = key_state_q[i];
        end
      end
      emit_last = (emit_idx == IDX_LAST);
    end
  end

  // Walk pointer: ascends one key per cycle while emitting, parked at 0 otherwise
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      emit_idx <= '0;
    end else if (state_q == EMIT) begin
      emit_idx <= emit_idx + 1'b1;
    end else begin
      emit_idx <= '0;
    end
  end

  // Registered event outputs; value/type hold between strobes, multi-key flag lags the bitmap by one cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      flag_q  <= 1'b0;
      press_q <= 1'b0;
      value_q <= '0;
      multi_q <= 1'b0;
    end else begin
      flag_q  <= emit_hit;
      multi_q <= |(key_state_q & (key_state_q - 1'b1));
      if (emit_hit) begin
        press_q <= emit_press;
        value_q <= emit_idx;
      end
    end
  end

  assign kp.Key_Col   = key_col_q;
  assign kp.Key_State = key_state_q;
  assign kp.Key_Flag  = flag_q;
  assign kp.Key_Press = press_q;
  assign kp.Key_Value = value_q;
  assign kp.Key_Multi = multi_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Testbench for key_matrix_scan: keypad models on the pins, expected events
// queued at stimulus time and consumed as the scanner strobes them.
module tb_key_matrix_scan;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 8;
  localparam int DEB_FRAMES = 3;
  localparam int ROWS_B     = 2;
  localparam int COLS_B     = 3;

  typedef struct {
    logic        press;
    logic [3:0]  value;
    logic [15:0] state;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys_a;
  logic [5:0]  keys_b;
  logic [3:0]  row_a;
  logic [1:0]  row_b;
  logic [3:0]  exp_col_a;
  logic [2:0]  exp_col_b;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          elapsed;
  int          d;
  bit          got_b;
  ev_t         exp_q[$];
  int          flag_times[$];

  key_matrix_scan_if #(.ROWS(ROWS),   .COLS(COLS))   a_if ();
  key_matrix_scan_if #(.ROWS(ROWS_B), .COLS(COLS_B)) b_if ();

  key_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)
  ) dut_a (
    .Clk(clk), .Rst_n(rst_n), .kp(a_if)
  );

  key_matrix_scan #(
    .ROWS(ROWS_B), .COLS(COLS_B), .SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)
  ) dut_b (
    .Clk(clk), .Rst_n(rst_n), .kp(b_if)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4x4 keypad model: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_a = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys_a[r*COLS + c] && !a_if.Key_Col[c]) row_a[r] = 1'b0;
  end
  assign a_if.Key_Row = row_a;

  // 2x3 keypad model for the small-matrix instance
  always_comb begin
    row_b = '1;
    for (int r = 0; r < ROWS_B; r++)
      for (int c = 0; c < COLS_B; c++)
        if (keys_b[r*COLS_B + c] && !b_if.Key_Col[c]) row_b[r] = 1'b0;
  end
  assign b_if.Key_Row = row_b;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_event(input logic press, input logic [3:0] value, input logic [15:0] state);
    ev_t e;
    e.press = press;
    e.value = value;
    e.state = state;
    exp_q.push_back(e);
  endtask

  // Runs n cycles, matching every strobe of the 4x4 scanner against the queue
  task automatic watch(input int n, input bit stop_at_flag);
    ev_t e;
    bit  got;
    got = 1'b0;
    for (int i = 0; i < n && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (a_if.Key_Flag !== 1'b0) begin
        flag_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_output("unexpected_flag", a_if.Key_Flag, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("event_value", a_if.Key_Value, e.value);
          check_output("event_press", a_if.Key_Press, e.press);
          check_output("event_state", a_if.Key_State, e.state);
        end
        if (stop_at_flag) got = 1'b1;
      end
    end
    if (stop_at_flag) check_output("flag_wait", got, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_col"},   a_if.Key_Col,   32'hE);
    check_output({tag, "_state"}, a_if.Key_State, 32'd0);
    check_output({tag, "_flag"},  a_if.Key_Flag,  32'd0);
    check_output({tag, "_press"}, a_if.Key_Press, 32'd0);
    check_output({tag, "_value"}, a_if.Key_Value, 32'd0);
    check_output({tag, "_multi"}, a_if.Key_Multi, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    keys_a = '0;
    keys_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Idle scanning: one-cold column rotates every SCAN_DIV cycles, no events
    $display("[TB] case 1: idle column scan");
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      exp_col_a = ~(4'b0001 << ((k / SCAN_DIV) % COLS));
      check_output("col_scan", a_if.Key_Col, exp_col_a);
      check_output("idle_flag", a_if.Key_Flag, 32'd0);
    end

    // Clean press and release of (row1,col2)
    $display("[TB] case 2: clean hold of key 6");
    keys_a[6] = 1'b1;
    expect_event(1'b1, 4'd6, 16'h0040);
    watch(300, 1'b0);
    check_output("pending_press6", exp_q.size(), 32'd0);
    keys_a[6] = 1'b0;
    expect_event(1'b0, 4'd6, 16'h0000);
    watch(300, 1'b0);
    check_output("pending_release6", exp_q.size(), 32'd0);

    // Bouncing (row2,col1): short bursts never give three matching frames
    $display("[TB] case 3: bounce on key 9");
    elapsed = 0;
    while (elapsed < 56) begin
      keys_a[9] = ~keys_a[9];
      d = $urandom_range(1, 40);
      if (d > 56 - elapsed) d = 56 - elapsed;
      watch(d, 1'b0);
      elapsed += d;
    end
    keys_a[9] = 1'b1;
    expect_event(1'b1, 4'd9, 16'h0200);
    watch(300, 1'b0);
    check_output("pending_press9", exp_q.size(), 32'd0);
    keys_a[9] = 1'b0;
    expect_event(1'b0, 4'd9, 16'h0000);
    watch(300, 1'b0);
    check_output("pending_release9", exp_q.size(), 32'd0);

    // Two corners pressed in the same frame: two ordered strobes 15 cycles apart
    $display("[TB] case 4: keys 0 and 15 together");
    flag_times.delete();
    keys_a = 16'h8001;
    expect_event(1'b1, 4'd0,  16'h8001);
    expect_event(1'b1, 4'd15, 16'h8001);
    watch(300, 1'b0);
    check_output("pending_multi_press", exp_q.size(), 32'd0);
    check_output("multi_flag_count", flag_times.size(), 32'd2);
    if (flag_times.size() >= 2)
      check_output("multi_flag_gap", flag_times[1] - flag_times[0], 32'd15);
    check_output("multi_on", a_if.Key_Multi, 32'd1);
    keys_a = 16'h0000;
    expect_event(1'b0, 4'd0,  16'h0000);
    expect_event(1'b0, 4'd15, 16'h0000);
    watch(300, 1'b0);
    check_output("pending_multi_release", exp_q.size(), 32'd0);
    check_output("multi_off", a_if.Key_Multi, 32'd0);

    // Reset during the emit walk cancels the rest; held keys come back afterwards
    $display("[TB] case 5: reset during emit");
    keys_a = 16'h8001;
    expect_event(1'b1, 4'd0,  16'h8001);
    expect_event(1'b1, 4'd15, 16'h8001);
    watch(300, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midemit_reset");
    exp_q.delete();
    watch(20, 1'b0);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    expect_event(1'b1, 4'd0,  16'h8001);
    expect_event(1'b1, 4'd15, 16'h8001);
    watch(300, 1'b0);
    check_output("pending_rereport", exp_q.size(), 32'd0);
    keys_a = 16'h0000;
    expect_event(1'b0, 4'd0,  16'h0000);
    expect_event(1'b0, 4'd15, 16'h0000);
    watch(300, 1'b0);
    check_output("pending_rerelease", exp_q.size(), 32'd0);

    // 2x3 instance: three-column rotation and top key index
    $display("[TB] case 6: 2x3 matrix");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      exp_col_b = ~(3'b001 << ((k / SCAN_DIV) % COLS_B));
      check_output("col_scan_b", b_if.Key_Col, exp_col_b);
    end
    keys_b[5] = 1'b1;
    got_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_if.Key_Flag === 1'b1 && !got_b) begin
        got_b = 1'b1;
        check_output("b_value", b_if.Key_Value, 32'd5);
        check_output("b_press", b_if.Key_Press, 32'd1);
        check_output("b_state", b_if.Key_State, 32'h20);
      end
    end
    check_output("b_flag_seen", got_b, 32'd1);
    check_output("b_multi", b_if.Key_Multi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
